// File: rtl/reg_dump_reader_pkg.sv
// Shared constants and state encoding for the register-bank dump reader.
package reg_dump_reader_pkg;

  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned STATE_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_SEL  = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/reg_dump_reader.sv
// Walks a contiguous register index range through the bank's auxiliary read
// port and streams {index, value} pairs over a valid/ready handshake.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic              iCLK,
  input  logic              iCLR,
  input  logic              iStart,
  input  logic [ADDR_W-1:0] iFirst,
  input  logic [ADDR_W-1:0] iLast,
  input  logic              iAbort,
  output logic [ADDR_W-1:0] oRegSelect,
  input  logic [DATA_W-1:0] iRegData,
  output logic              oValid,
  input  logic              iReady,
  output logic [ADDR_W-1:0] oIdx,
  output logic [DATA_W-1:0] oData,
  output logic              oBusy,
  output logic              oDone
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              hs_c;

  assign hs_c = valid_q && iReady;

  // State register
  always_ff @(posedge iCLK or posedge iCLR) begin
    if (iCLR) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (iStart) state_d = ST_SEL;
      ST_SEL:  state_d = ST_OUT;
      ST_OUT:  if (hs_c) state_d = (cur_q == last_q) ? ST_DONE : ST_SEL;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (iAbort) state_d = ST_IDLE;
  end

  // Output and datapath next values; status flags decode the next state so
  // they leave the flops aligned with the state they describe
  always_comb begin
    valid_d = (state_d == ST_OUT);
    done_d  = (state_d == ST_DONE);
    busy_d  = (state_d != ST_IDLE);
    cur_d   = cur_q;
    last_d  = last_q;
    idx_d   = idx_q;
    data_d  = data_q;
    if (!iAbort) begin
      case (state_q)
        ST_IDLE: begin
          if (iStart) begin
            cur_d  = iFirst;
            last_d = iLast;
          end
        end
        ST_SEL: begin
          idx_d  = cur_q;
          data_d = iRegData;
        end
        ST_OUT: begin
          if (hs_c && (cur_q != last_q)) cur_d = cur_q + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge iCLK or posedge iCLR) begin
    if (iCLR) begin
      cur_q   <= '0;
      last_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      cur_q   <= cur_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign oRegSelect = cur_q;
  assign oIdx       = idx_q;
  assign oData      = data_q;
  assign oValid     = valid_q;
  assign oBusy      = busy_q;
  assign oDone      = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: stimulus queues expected words, a
// negedge monitor pops and compares on every handshake.
module tb_reg_dump_reader;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  logic              iCLK   = 1'b0;
  logic              iCLR   = 1'b1;
  logic              iStart = 1'b0;
  logic [ADDR_W-1:0] iFirst = '0;
  logic [ADDR_W-1:0] iLast  = '0;
  logic              iAbort = 1'b0;
  logic              iReady = 1'b1;
  logic [ADDR_W-1:0] oRegSelect;
  logic [DATA_W-1:0] iRegData;
  logic              oValid;
  logic [ADDR_W-1:0] oIdx;
  logic [DATA_W-1:0] oData;
  logic              oBusy;
  logic              oDone;

  logic [DATA_W-1:0] bank [32];
  assign iRegData = bank[oRegSelect];

  reg_dump_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .iCLK       (iCLK),
    .iCLR       (iCLR),
    .iStart     (iStart),
    .iFirst     (iFirst),
    .iLast      (iLast),
    .iAbort     (iAbort),
    .oRegSelect (oRegSelect),
    .iRegData   (iRegData),
    .oValid     (oValid),
    .iReady     (iReady),
    .oIdx       (oIdx),
    .oData      (oData),
    .oBusy      (oBusy),
    .oDone      (oDone)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] data;
  } word_t;

  word_t exp_q[$];
  int    done_exp = 0;
  int    checks   = 0;
  int    errors   = 0;
  int    cyc      = 0;

  always @(posedge iCLK) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: handshakes, stall stability, done pulses
  logic              stall_prev = 1'b0;
  logic [ADDR_W-1:0] stall_idx;
  logic [DATA_W-1:0] stall_data;
  always @(negedge iCLK) begin
    word_t w;
    if (iCLR) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 64'(oValid), 64'd1);
        check("stall_idx", 64'(oIdx), 64'(stall_idx));
        check("stall_data", 64'(oData), 64'(stall_data));
      end
      stall_prev = oValid && !iReady && !iAbort;
      stall_idx  = oIdx;
      stall_data = oData;
      if (oValid && iReady) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got idx %0d data %0h expected no word", oIdx, oData);
        end else begin
          w = exp_q.pop_front();
          check("word_idx", 64'(oIdx), 64'(w.idx));
          check("word_data", 64'(oData), 64'(w.data));
        end
      end
      if (oDone) begin
        check("done_expected", 64'(done_exp > 0), 64'd1);
        check("done_words_left", 64'(exp_q.size()), 64'd0);
        if (done_exp > 0) done_exp--;
      end
    end
  end

  task automatic push_range(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l);
    logic [ADDR_W-1:0] diff;
    logic [ADDR_W-1:0] ix;
    diff = l - f;
    for (int i = 0; i <= int'(diff); i++) begin
      ix = f + ADDR_W'(i);
      exp_q.push_back({ix, bank[ix]});
    end
  endtask

  task automatic run_dump(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l,
                          input int stall, input bit poke_start,
                          output int done_cyc, output int valid_cyc);
    int c0, stall_cnt;
    bit hs_prev, poked;
    push_range(f, l);
    done_exp  = 1;
    done_cyc  = -1;
    valid_cyc = -1;
    stall_cnt = 0;
    hs_prev   = 1'b0;
    poked     = 1'b0;
    iFirst = f;
    iLast  = l;
    iStart = 1'b1;
    c0     = cyc;
    for (int k = 0; k < 400; k++) begin
      @(posedge iCLK);
      #1;
      iStart = 1'b0;
      if (hs_prev) stall_cnt = 0;
      if (oValid && valid_cyc < 0) valid_cyc = cyc - c0;
      if (oDone) begin
        done_cyc = cyc - c0;
        break;
      end
      if (oValid && stall_cnt < stall) begin
        iReady = 1'b0;
        stall_cnt++;
        if (poke_start && !poked) begin
          iStart = 1'b1;
          iFirst = 5'd0;
          iLast  = 5'd31;
          poked  = 1'b1;
        end
      end else begin
        iReady = 1'b1;
      end
      hs_prev = oValid && iReady;
    end
    iReady = 1'b1;
    check("done_seen", 64'(done_cyc >= 0), 64'd1);
    check("words_left", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  int dc, vc;

  initial begin
    for (int i = 0; i < 32; i++) bank[i] = 32'h100 + 32'(i);
    bank[2] = 32'h0000_7FF0;

    // Reset values
    #12;
    check("rst_valid", 64'(oValid), 64'd0);
    check("rst_busy", 64'(oBusy), 64'd0);
    check("rst_done", 64'(oDone), 64'd0);
    check("rst_sel", 64'(oRegSelect), 64'd0);
    check("rst_idx", 64'(oIdx), 64'd0);
    check("rst_data", 64'(oData), 64'd0);
    @(posedge iCLK);
    #1;
    iCLR = 1'b0;
    @(posedge iCLK);
    #1;

    // Full dump 0..31
    run_dump(5'd0, 5'd31, 0, 1'b0, dc, vc);
    check("full_first_valid_cyc", 64'(vc), 64'd2);
    check("full_done_cyc", 64'(dc), 64'd65);
    #1;
    check("full_busy_in_done", 64'(oBusy), 64'd1);
    @(posedge iCLK);
    #1;
    check("full_idle_after", 64'(oBusy), 64'd0);

    // Backpressure 4..6, three stall cycles per word
    run_dump(5'd4, 5'd6, 3, 1'b0, dc, vc);
    check("bp_done_cyc", 64'(dc), 64'd16);
    @(posedge iCLK);
    #1;

    // Wrap 30..1
    run_dump(5'd30, 5'd1, 0, 1'b0, dc, vc);
    check("wrap_done_cyc", 64'(dc), 64'd9);
    @(posedge iCLK);
    #1;

    // Single word with ignored start during OUT
    run_dump(5'd7, 5'd7, 2, 1'b1, dc, vc);
    check("single_done_cyc", 64'(dc), 64'd5);
    repeat (4) begin
      @(posedge iCLK);
      #1;
      check("single_no_restart_busy", 64'(oBusy), 64'd0);
      check("single_no_restart_valid", 64'(oValid), 64'd0);
    end

    // Abort during the second word
    begin
      int seen;
      bit was_valid;
      bit aborted;
      push_range(5'd10, 5'd11);
      done_exp = 0;
      seen = 0;
      was_valid = 1'b0;
      aborted = 1'b0;
      iFirst = 5'd10;
      iLast  = 5'd20;
      iStart = 1'b1;
      for (int k = 0; k < 40 && !aborted; k++) begin
        @(posedge iCLK);
        #1;
        iStart = 1'b0;
        if (oValid && !was_valid) seen++;
        was_valid = oValid;
        if (seen == 2) begin
          iAbort  = 1'b1;
          aborted = 1'b1;
        end
      end
      check("abort_reached", 64'(aborted), 64'd1);
      @(posedge iCLK);
      #1;
      iAbort = 1'b0;
      check("abort_valid", 64'(oValid), 64'd0);
      check("abort_busy", 64'(oBusy), 64'd0);
      check("abort_done", 64'(oDone), 64'd0);
      repeat (4) begin
        @(posedge iCLK);
        #1;
        check("abort_quiet_done", 64'(oDone), 64'd0);
        check("abort_quiet_valid", 64'(oValid), 64'd0);
      end
      check("abort_words_left", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end

    // Asynchronous reset mid-dump, then a normal dump
    begin
      bit got;
      push_range(5'd0, 5'd31);
      done_exp = 0;
      got = 1'b0;
      iFirst = 5'd0;
      iLast  = 5'd31;
      iStart = 1'b1;
      for (int k = 0; k < 100 && !got; k++) begin
        @(posedge iCLK);
        #1;
        iStart = 1'b0;
        if (exp_q.size() <= 27) got = 1'b1;
      end
      check("clr_reached", 64'(got), 64'd1);
      #1;
      iCLR = 1'b1;
      #1;
      check("clr_valid", 64'(oValid), 64'd0);
      check("clr_busy", 64'(oBusy), 64'd0);
      check("clr_done", 64'(oDone), 64'd0);
      check("clr_sel", 64'(oRegSelect), 64'd0);
      check("clr_idx", 64'(oIdx), 64'd0);
      check("clr_data", 64'(oData), 64'd0);
      exp_q.delete();
      repeat (2) @(posedge iCLK);
      #1;
      check("clr_hold_done", 64'(oDone), 64'd0);
      iCLR = 1'b0;
      @(posedge iCLK);
      #1;
      bank[29] = 32'hDEAD_BEEF;
      run_dump(5'd28, 5'd3, 1, 1'b0, dc, vc);
      check("post_clr_first_valid_cyc", 64'(vc), 64'd2);
      check("post_clr_done_cyc", 64'(dc), 64'd25);
    end

    repeat (3) @(posedge iCLK);
    #1;
    check("end_idle", 64'(oBusy), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
